// File: rtl/snes_rom_loader_pkg.sv
// rtl/snes_rom_loader_pkg.sv - shared state, header layout and write-entry types for the ROM loader
package snes_rom_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam int unsigned HDR_LEN   = 64;
  localparam int unsigned HDR_MAP   = 'h15;
  localparam int unsigned HDR_TYPE  = 'h16;
  localparam int unsigned HDR_ROMSZ = 'h17;
  localparam int unsigned HDR_RAMSZ = 'h18;

  typedef struct packed {
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  ds;
  } wr_entry_t;

  // Smallest all-ones mask covering byte offsets 0..n-1; an empty ROM gives 0.
  function automatic logic [22:0] pow2_mask(input logic [23:0] n);
    logic [23:0] m;
    m = (n == 24'd0) ? 24'd0 : n - 24'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m[22:0] | {23{m[23]}};
  endfunction

endpackage

// File: rtl/snes_rom_loader_if.sv
// rtl/snes_rom_loader_if.sv - SDRAM ROM write port between the loader and the SDRAM arbiter
interface snes_rom_loader_if;
  logic        mem_wr;
  logic [21:0] mem_waddr;
  logic [15:0] mem_din;
  logic [1:0]  mem_ds;
  logic        mem_ack;

  modport master (output mem_wr, mem_waddr, mem_din, mem_ds, input mem_ack);
  modport slave  (input mem_wr, mem_waddr, mem_din, mem_ds, output mem_ack);
endinterface

// File: rtl/snes_rom_loader_word_fifo.sv
// rtl/snes_rom_loader_word_fifo.sv - first-word-fall-through buffer of pending SDRAM word writes
module loader_word_fifo
  import snes_rom_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      clear_i,
  input  logic      push_i,
  input  wr_entry_t push_entry_i,
  input  logic      pop_i,
  output wr_entry_t head_o,
  output logic      empty_o,
  output logic      full_o,
  output logic      last_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  wr_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          pop_ok;
  logic          push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign last_o  = (count_q == CNT_ONE);
  assign pop_ok  = pop_i && !empty_o;
  // A pop in the same cycle frees a slot, so a push while full is still taken.
  assign push_ok = push_i && (!full_o || pop_ok);
  // Masked head keeps the bus at zero whenever nothing is requested.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!resetn || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

// File: rtl/snes_rom_loader.sv
// rtl/snes_rom_loader.sv - splits the iosys ROM byte stream into captured header bytes and SDRAM word writes
module snes_rom_loader
  import snes_rom_loader_pkg::*;
#(
  parameter int unsigned BASE_WADDR = 0,
  parameter int unsigned MAX_BYTES  = 8388608,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     rom_loading_i,
  input  logic [7:0]               rom_do_i,
  input  logic                     rom_do_valid_i,
  snes_rom_loader_if.master        mem,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [23:0]              rom_bytes_o,
  output logic [22:0]              rom_mask_o,
  output logic [7:0]               map_mode_o,
  output logic [7:0]               rom_type_o,
  output logic [7:0]               rom_size_o,
  output logic [7:0]               ram_size_o,
  output logic                     header_valid_o,
  output logic                     overflow_o
);

  state_e      state_q;
  logic        loading_q;
  logic [5:0]  hdr_cnt_q;
  logic [7:0]  low_q;
  logic        have_low_q;
  logic [21:0] word_idx_q;
  logic        push_q;
  wr_entry_t   push_entry_q;
  logic [23:0] rom_bytes_q;
  logic [22:0] rom_mask_q;
  logic [7:0]  map_mode_q;
  logic [7:0]  rom_type_q;
  logic [7:0]  rom_size_q;
  logic [7:0]  ram_size_q;
  logic        header_valid_q;
  logic        overflow_q;
  logic        done_q;

  logic        rise_d;
  logic        fall_d;
  logic        byte_ok_d;
  logic        accept_d;
  logic        drained_d;
  logic [21:0] next_addr_d;
  logic        fifo_clear;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_last;
  logic        fifo_pop;
  logic        fifo_drop;
  wr_entry_t   fifo_head;

  assign rise_d      = rom_loading_i && !loading_q;
  assign fall_d      = !rom_loading_i && loading_q;
  assign byte_ok_d   = ({8'd0, rom_bytes_q} < MAX_BYTES);
  assign accept_d    = rom_do_valid_i && byte_ok_d;
  assign next_addr_d = 22'(BASE_WADDR) + word_idx_q;
  assign fifo_clear  = (state_q == ST_IDLE) && rise_d;
  assign fifo_pop    = mem.mem_ack && !fifo_empty;
  assign fifo_drop   = push_q && fifo_full && !fifo_pop;
  // Drained already in the ack cycle of the last entry, so done trails that ack by one cycle.
  assign drained_d   = !push_q && (fifo_empty || (fifo_last && fifo_pop));

  loader_word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .clear_i     (fifo_clear),
    .push_i      (push_q),
    .push_entry_i(push_entry_q),
    .pop_i       (mem.mem_ack),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .last_o      (fifo_last)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      loading_q      <= 1'b0;
      hdr_cnt_q      <= '0;
      low_q          <= '0;
      have_low_q     <= 1'b0;
      word_idx_q     <= '0;
      push_q         <= 1'b0;
      push_entry_q   <= '0;
      rom_bytes_q    <= '0;
      rom_mask_q     <= '0;
      map_mode_q     <= '0;
      rom_type_q     <= '0;
      rom_size_q     <= '0;
      ram_size_q     <= '0;
      header_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      loading_q <= rom_loading_i;
      push_q    <= 1'b0;
      done_q    <= 1'b0;
      if (fifo_drop) overflow_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (rise_d) begin
            state_q        <= ST_HEADER;
            hdr_cnt_q      <= '0;
            have_low_q     <= 1'b0;
            word_idx_q     <= '0;
            rom_bytes_q    <= '0;
            rom_mask_q     <= '0;
            map_mode_q     <= '0;
            rom_type_q     <= '0;
            rom_size_q     <= '0;
            ram_size_q     <= '0;
            header_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
          end
        end
        ST_HEADER: begin
          if (rom_do_valid_i) begin
            hdr_cnt_q <= hdr_cnt_q + 6'd1;
            if (hdr_cnt_q == 6'(HDR_MAP))   map_mode_q <= rom_do_i;
            if (hdr_cnt_q == 6'(HDR_TYPE))  rom_type_q <= rom_do_i;
            if (hdr_cnt_q == 6'(HDR_ROMSZ)) rom_size_q <= rom_do_i;
            if (hdr_cnt_q == 6'(HDR_RAMSZ)) ram_size_q <= rom_do_i;
            if (hdr_cnt_q == 6'(HDR_LEN - 1)) begin
              header_valid_q <= 1'b1;
              state_q        <= ST_DATA;
            end
          end
          if (fall_d) state_q <= ST_FLUSH;
        end
        ST_DATA: begin
          if (rom_do_valid_i && !byte_ok_d) overflow_q <= 1'b1;
          if (accept_d) rom_bytes_q <= rom_bytes_q + 24'd1;
          if (accept_d && have_low_q) begin
            push_q       <= 1'b1;
            push_entry_q <= '{addr: next_addr_d, data: {rom_do_i, low_q}, ds: 2'b11};
            word_idx_q   <= word_idx_q + 22'd1;
            have_low_q   <= 1'b0;
          end else if (accept_d && fall_d) begin
            push_q       <= 1'b1;
            push_entry_q <= '{addr: next_addr_d, data: {8'h00, rom_do_i}, ds: 2'b01};
            word_idx_q   <= word_idx_q + 22'd1;
          end else if (accept_d) begin
            low_q      <= rom_do_i;
            have_low_q <= 1'b1;
          end else if (fall_d && have_low_q) begin
            push_q       <= 1'b1;
            push_entry_q <= '{addr: next_addr_d, data: {8'h00, low_q}, ds: 2'b01};
            word_idx_q   <= word_idx_q + 22'd1;
            have_low_q   <= 1'b0;
          end
          if (fall_d) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (drained_d) begin
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            rom_mask_q <= pow2_mask(rom_bytes_q);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_wr    = !fifo_empty;
  assign mem.mem_waddr = fifo_head.addr;
  assign mem.mem_din   = fifo_head.data;
  assign mem.mem_ds    = fifo_head.ds;

  assign busy_o         = (state_q != ST_IDLE) || !fifo_empty;
  assign done_o         = done_q;
  assign rom_bytes_o    = rom_bytes_q;
  assign rom_mask_o     = rom_mask_q;
  assign map_mode_o     = map_mode_q;
  assign rom_type_o     = rom_type_q;
  assign rom_size_o     = rom_size_q;
  assign ram_size_o     = ram_size_q;
  assign header_valid_o = header_valid_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_snes_rom_loader.sv
// tb/tb_snes_rom_loader.sv - directed bench for snes_rom_loader with an SDRAM ack responder
module tb_snes_rom_loader;

  logic        clk;
  logic        resetn;
  logic        rom_loading;
  logic [7:0]  rom_do;
  logic        rom_do_valid;
  logic        busy_o;
  logic        done_o;
  logic [23:0] rom_bytes_o;
  logic [22:0] rom_mask_o;
  logic [7:0]  map_mode_o;
  logic [7:0]  rom_type_o;
  logic [7:0]  rom_size_o;
  logic [7:0]  ram_size_o;
  logic        header_valid_o;
  logic        overflow_o;

  snes_rom_loader_if mem_if ();

  snes_rom_loader #(
    .MAX_BYTES(1024)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .rom_loading_i (rom_loading),
    .rom_do_i      (rom_do),
    .rom_do_valid_i(rom_do_valid),
    .mem           (mem_if.master),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .rom_bytes_o   (rom_bytes_o),
    .rom_mask_o    (rom_mask_o),
    .map_mode_o    (map_mode_o),
    .rom_type_o    (rom_type_o),
    .rom_size_o    (rom_size_o),
    .ram_size_o    (ram_size_o),
    .header_valid_o(header_valid_o),
    .overflow_o    (overflow_o)
  );

  int checks = 0;
  int failures = 0;
  int ack_delay = 0;
  logic ack_block = 1'b0;
  int wait_cnt = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_ack_cyc = 0;
  int wr_cycles = 0;
  logic [21:0] la [$];
  logic [15:0] ld [$];
  logic [1:0]  lds [$];
  int d0;
  int w0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // SDRAM side: acks each request ack_delay cycles after it appears, logging accepted writes.
  initial begin
    mem_if.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mem_if.mem_wr) wr_cycles++;
      mem_if.mem_ack = 1'b0;
      if (mem_if.mem_wr && !ack_block) begin
        if (wait_cnt >= ack_delay) begin
          mem_if.mem_ack = 1'b1;
          wait_cnt = 0;
          last_ack_cyc = cyc;
          la.push_back(mem_if.mem_waddr);
          ld.push_back(mem_if.mem_din);
          lds.push_back(mem_if.mem_ds);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    la.delete();
    ld.delete();
    lds.delete();
  endtask

  task automatic send(input logic [7:0] b);
    rom_do = b;
    rom_do_valid = 1'b1;
    @(negedge clk);
    rom_do_valid = 1'b0;
  endtask

  task automatic send_data(input int n);
    for (int i = 0; i < n; i++) begin
      send(8'(i));
      if (i % 4 == 3) @(negedge clk);
    end
  endtask

  task automatic send_header(input int n, input logic [7:0] map, input logic [7:0] romsz);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'(i) ^ 8'h5A;
      if (i == 'h15) b = map;
      if (i == 'h16) b = 8'h02;
      if (i == 'h17) b = romsz;
      if (i == 'h18) b = 8'h03;
      send(b);
      if (i % 4 == 3) @(negedge clk);
    end
  endtask

  task automatic start_load();
    rom_loading = 1'b1;
    @(negedge clk);
  endtask

  task automatic finish_load(input string tag);
    logic seen;
    seen = 1'b0;
    rom_loading = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    rom_loading = 1'b0;
    rom_do = 8'h00;
    rom_do_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_wr", 32'(mem_if.mem_wr), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_rom_bytes", 32'(rom_bytes_o), 0);
    chk("rst_rom_mask", 32'(rom_mask_o), 0);
    chk("rst_header_valid", 32'(header_valid_o), 0);
    chk("rst_overflow", 32'(overflow_o), 0);
    resetn = 1'b1;
    @(negedge clk);

    // Header + 8 data bytes, slow acks.
    ack_delay = 3;
    clear_log();
    d0 = done_cnt;
    start_load();
    chk("t1_busy", 32'(busy_o), 1);
    send_header(64, 8'h21, 8'h0A);
    chk("t1_header_valid", 32'(header_valid_o), 1);
    send_data(8);
    finish_load("t1");
    chk("t1_nwrites", 32'(la.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < la.size()) begin
        chk("t1_waddr", 32'(la[i]), 32'(i));
        chk("t1_wdata", 32'(ld[i]), 32'({8'(2 * i + 1), 8'(2 * i)}));
        chk("t1_wds", 32'(lds[i]), 3);
      end
    end
    chk("t1_map_mode", 32'(map_mode_o), 'h21);
    chk("t1_rom_type", 32'(rom_type_o), 'h02);
    chk("t1_rom_size", 32'(rom_size_o), 'h0A);
    chk("t1_ram_size", 32'(ram_size_o), 'h03);
    chk("t1_rom_bytes", 32'(rom_bytes_o), 8);
    chk("t1_rom_mask", 32'(rom_mask_o), 7);
    chk("t1_overflow", 32'(overflow_o), 0);
    chk("t1_busy_after", 32'(busy_o), 0);
    chk("t1_done_count", 32'(done_cnt - d0), 1);
    chk("t1_done_after_ack", 32'(done_cyc - last_ack_cyc), 1);

    // Odd data length leaves a lone low byte.
    ack_delay = 0;
    clear_log();
    start_load();
    send_header(64, 8'h20, 8'h08);
    send_data(5);
    finish_load("t2");
    chk("t2_nwrites", 32'(la.size()), 3);
    if (la.size() == 3) begin
      chk("t2_w1_data", 32'(ld[1]), 'h0302);
      chk("t2_last_addr", 32'(la[2]), 2);
      chk("t2_last_data", 32'(ld[2]), 'h0004);
      chk("t2_last_ds", 32'(lds[2]), 1);
    end
    chk("t2_rom_bytes", 32'(rom_bytes_o), 5);
    chk("t2_rom_mask", 32'(rom_mask_o), 7);

    // Acks withheld while bursts arrive: FIFO overruns.
    clear_log();
    ack_block = 1'b1;
    start_load();
    send_header(64, 8'h21, 8'h0A);
    for (int i = 0; i < 24; i++) begin
      send(8'(i));
      if (i % 4 == 3) repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("t3_mem_wr_held", 32'(mem_if.mem_wr), 1);
    chk("t3_overflow", 32'(overflow_o), 1);
    ack_block = 1'b0;
    finish_load("t3");
    chk("t3_nwrites", 32'(la.size()), 4);
    if (la.size() == 4) begin
      chk("t3_w0_data", 32'(ld[0]), 'h0100);
      chk("t3_w3_addr", 32'(la[3]), 3);
      chk("t3_w3_data", 32'(ld[3]), 'h0706);
    end
    chk("t3_overflow_sticky", 32'(overflow_o), 1);
    chk("t3_rom_bytes", 32'(rom_bytes_o), 24);
    chk("t3_rom_mask", 32'(rom_mask_o), 'h1F);

    // Load aborted inside the header.
    d0 = done_cnt;
    w0 = wr_cycles;
    start_load();
    send_header(30, 8'h21, 8'h0A);
    rom_loading = 1'b0;
    @(negedge clk);
    chk("t4_done_early", 32'(done_o), 0);
    @(negedge clk);
    chk("t4_done_at_2", 32'(done_o), 1);
    repeat (3) @(negedge clk);
    chk("t4_no_writes", 32'(wr_cycles - w0), 0);
    chk("t4_header_valid", 32'(header_valid_o), 0);
    chk("t4_rom_bytes", 32'(rom_bytes_o), 0);
    chk("t4_rom_mask", 32'(rom_mask_o), 0);
    chk("t4_overflow", 32'(overflow_o), 0);
    chk("t4_done_count", 32'(done_cnt - d0), 1);

    // Non-power-of-two size just past 768 bytes.
    clear_log();
    start_load();
    send_header(64, 8'h21, 8'h0A);
    send_data(769);
    finish_load("t5");
    chk("t5_nwrites", 32'(la.size()), 385);
    if (la.size() == 385) begin
      chk("t5_w383_data", 32'(ld[383]), 'hFFFE);
      chk("t5_w383_ds", 32'(lds[383]), 3);
      chk("t5_last_addr", 32'(la[384]), 384);
      chk("t5_last_ds", 32'(lds[384]), 1);
    end
    chk("t5_rom_bytes", 32'(rom_bytes_o), 'h301);
    chk("t5_rom_mask", 32'(rom_mask_o), 'h3FF);
    chk("t5_overflow", 32'(overflow_o), 0);

    // More data than the 1024-byte limit of this instance.
    clear_log();
    start_load();
    send_header(64, 8'h21, 8'h0A);
    send_data(1030);
    finish_load("t6");
    chk("t6_nwrites", 32'(la.size()), 512);
    if (la.size() == 512) chk("t6_last_data", 32'(ld[511]), 'hFFFE);
    chk("t6_rom_bytes", 32'(rom_bytes_o), 1024);
    chk("t6_rom_mask", 32'(rom_mask_o), 'h3FF);
    chk("t6_overflow", 32'(overflow_o), 1);

    // Reset in the middle of the data phase with a write pending.
    ack_block = 1'b1;
    start_load();
    send_header(64, 8'h33, 8'h0C);
    send_data(6);
    repeat (3) @(negedge clk);
    chk("t7_pending", 32'(mem_if.mem_wr), 1);
    d0 = done_cnt;
    resetn = 1'b0;
    rom_loading = 1'b0;
    @(negedge clk);
    chk("t7_rst_mem_wr", 32'(mem_if.mem_wr), 0);
    chk("t7_rst_waddr", 32'(mem_if.mem_waddr), 0);
    chk("t7_rst_din", 32'(mem_if.mem_din), 0);
    chk("t7_rst_busy", 32'(busy_o), 0);
    chk("t7_rst_header_valid", 32'(header_valid_o), 0);
    chk("t7_rst_rom_bytes", 32'(rom_bytes_o), 0);
    chk("t7_rst_map_mode", 32'(map_mode_o), 0);
    resetn = 1'b1;
    ack_block = 1'b0;
    repeat (3) @(negedge clk);
    chk("t7_no_done", 32'(done_cnt - d0), 0);
    clear_log();
    start_load();
    send_header(64, 8'h21, 8'h0A);
    send_data(4);
    finish_load("t7");
    chk("t7_nwrites", 32'(la.size()), 2);
    if (la.size() == 2) begin
      chk("t7_w0_addr", 32'(la[0]), 0);
      chk("t7_w0_data", 32'(ld[0]), 'h0100);
      chk("t7_w1_addr", 32'(la[1]), 1);
    end
    chk("t7_rom_bytes", 32'(rom_bytes_o), 4);
    chk("t7_rom_mask", 32'(rom_mask_o), 3);
    chk("t7_overflow", 32'(overflow_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
